// File: rtl/mcpu_soc_mmio_pkg.sv
// Shared definitions for the MMIO fabric: FSM states, slot map and
// status-window layout.
package mcpu_soc_mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mmio_state_e;

    localparam int          SLOT_SHIFT   = 12;
    localparam logic [9:0]  ERR_ADDR_OFS = 10'd0;
    localparam logic [9:0]  ERR_STAT_OFS = 10'd1;

    localparam int SLOT_LEDSW = 0;
    localparam int SLOT_UART  = 1;
    localparam int SLOT_I2C   = 2;
    localparam int SLOT_SD    = 3;
    localparam int SLOT_AUDIO = 4;
    localparam int SLOT_VIDEO = 5;
    localparam int SLOT_ICTL  = 6;

    function automatic logic [31:0] expand_wren(input logic [3:0] wren);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{wren[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mcpu_soc_mmio_errlog.sv
// Bus-error log: first failing address, saturating error count and the
// sticky error interrupt, with software clear.
module mcpu_soc_mmio_errlog
    import mcpu_soc_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        log_err,
    input  logic [28:0] log_addr,
    input  logic        clr,
    output logic [28:0] err_addr,
    output logic [15:0] err_count,
    output logic        err_irq
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr  <= '0;
            err_count <= '0;
            err_irq   <= 1'b0;
        end else if (log_err) begin
            // A new error outranks a coincident software clear.
            if (err_count == 16'd0) begin
                err_addr <= log_addr;
            end
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            err_irq <= 1'b1;
        end else if (clr) begin
            err_count <= '0;
            err_irq   <= 1'b0;
        end
    end

endmodule

// File: rtl/mcpu_soc_mmio_fabric.sv
// Registered MMIO fabric: decodes the core's uncached port onto 4 KiB
// peripheral slots with ready handshake, timeout watchdog and error log.
module mcpu_soc_mmio_fabric
    import mcpu_soc_mmio_pkg::*;
#(
    parameter int          NUM_SLOTS      = 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0
) (
    input  logic                      clkrst_core_clk,
    input  logic                      clkrst_core_rst_n,
    input  logic                      cpu_req,
    input  logic [28:0]               cpu_addr,
    input  logic [3:0]                cpu_wren,
    input  logic [31:0]               cpu_wdata,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_ack,
    output logic                      cpu_err,
    output logic [NUM_SLOTS-1:0]      slv_sel,
    output logic [9:0]                slv_addr,
    output logic [31:0]               slv_write_mask,
    output logic [31:0]               slv_wdata,
    input  logic [32*NUM_SLOTS-1:0]   slv_rdata,
    input  logic [NUM_SLOTS-1:0]      slv_ready,
    output logic                      err_irq
);

    localparam logic [18:0] STATUS_SLOT = 19'(NUM_SLOTS);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    mmio_state_e state_q, state_d;

    logic [28:0] req_addr_q;
    logic [3:0]  req_wren_q;
    logic [31:0] req_wdata_q;
    logic [4:0]  slot_q;
    logic [15:0] tmo_cnt_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;

    logic [18:0] cpu_slot;
    logic        cpu_is_slot, cpu_is_status;
    logic        in_wait, in_resp, ready_hit, tmo_hit;
    logic [31:0] slot_rdata, status_rdata;
    logic        req_is_status, log_err, clr_err;
    logic [28:0] err_addr;
    logic [15:0] err_count;

    assign cpu_slot      = cpu_addr[28:SLOT_SHIFT-2];
    assign cpu_is_slot   = cpu_slot < STATUS_SLOT;
    assign cpu_is_status = cpu_slot == STATUS_SLOT;
    assign in_wait       = state_q == ST_WAIT;
    assign in_resp       = state_q == ST_RESP;
    assign tmo_hit       = tmo_cnt_q == TMO_LAST;

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) state_q <= ST_IDLE;
        else                    state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cpu_req) state_d = cpu_is_slot ? ST_WAIT : ST_RESP;
            ST_WAIT: if (ready_hit || tmo_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_hit  = 1'b0;
        slot_rdata = '0;
        slv_sel    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == 5'(i)) begin
                ready_hit  = slv_ready[i];
                slot_rdata = slv_rdata[32*i +: 32];
                slv_sel[i] = in_wait;
            end
        end
    end

    // Status reads are captured at acceptance; the log only moves on RESP.
    always_comb begin
        status_rdata = '0;
        if (cpu_addr[9:0] == ERR_ADDR_OFS)      status_rdata = {err_addr, 2'b00};
        else if (cpu_addr[9:0] == ERR_STAT_OFS) status_rdata = {err_count, 15'b0, err_irq};
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            req_addr_q  <= '0;
            req_wren_q  <= '0;
            req_wdata_q <= '0;
            slot_q      <= '0;
            tmo_cnt_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (cpu_req) begin
                    req_addr_q  <= cpu_addr;
                    req_wren_q  <= cpu_wren;
                    req_wdata_q <= cpu_wdata;
                    slot_q      <= cpu_addr[14:10];
                    tmo_cnt_q   <= '0;
                    resp_data_q <= status_rdata;
                    resp_err_q  <= !cpu_is_slot && !cpu_is_status;
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (ready_hit)    resp_data_q <= slot_rdata;
                    else if (tmo_hit) resp_err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign slv_addr       = in_wait ? req_addr_q[9:0] : 10'd0;
    assign slv_wdata      = in_wait ? req_wdata_q : 32'h0;
    assign slv_write_mask = in_wait ? expand_wren(req_wren_q) : 32'h0;

    assign cpu_ack   = in_resp;
    assign cpu_err   = in_resp & resp_err_q;
    assign cpu_rdata = !in_resp    ? 32'h0 :
                       resp_err_q  ? ERR_RDATA :
                       |req_wren_q ? 32'h0 : resp_data_q;

    assign req_is_status = req_addr_q[28:10] == STATUS_SLOT;
    assign log_err       = in_resp & resp_err_q;
    assign clr_err       = in_resp && req_is_status && (|req_wren_q) &&
                           (req_addr_q[9:0] == ERR_STAT_OFS) && req_wdata_q[0];

    mcpu_soc_mmio_errlog u_errlog (
        .clk       (clkrst_core_clk),
        .rst_n     (clkrst_core_rst_n),
        .log_err   (log_err),
        .log_addr  (req_addr_q),
        .clr       (clr_err),
        .err_addr  (err_addr),
        .err_count (err_count),
        .err_irq   (err_irq)
    );

endmodule

// File: tb/tb_mcpu_soc_mmio_fabric.sv
// Self-checking bench for mcpu_soc_mmio_fabric: directed scenarios plus
// random accesses against a transaction-level reference model.
module tb_mcpu_soc_mmio_fabric;

    localparam int          NSLOT  = 8;
    localparam int          TMO    = 4;
    localparam logic [31:0] ERR_RD = 32'h0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic [28:0]  cpu_addr = '0;
    logic [3:0]   cpu_wren = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ack, cpu_err;
    logic [NSLOT-1:0] slv_sel;
    logic [9:0]   slv_addr;
    logic [31:0]  slv_write_mask, slv_wdata;
    logic [32*NSLOT-1:0] slv_rdata = '0;
    logic [NSLOT-1:0] slv_ready = '0;
    logic         err_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the error log
    logic [28:0] m_err_addr = '0;
    int          m_count    = 0;
    logic        m_irq      = 1'b0;

    always #5 clk = ~clk;

    mcpu_soc_mmio_fabric #(
        .NUM_SLOTS      (NSLOT),
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (ERR_RD)
    ) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .cpu_req           (cpu_req),
        .cpu_addr          (cpu_addr),
        .cpu_wren          (cpu_wren),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ack           (cpu_ack),
        .cpu_err           (cpu_err),
        .slv_sel           (slv_sel),
        .slv_addr          (slv_addr),
        .slv_write_mask    (slv_write_mask),
        .slv_wdata         (slv_wdata),
        .slv_rdata         (slv_rdata),
        .slv_ready         (slv_ready),
        .err_irq           (err_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] mk_addr(input int slot, input int ofs);
        return 29'((slot << 10) | (ofs & 10'h3FF));
    endfunction

    // One CPU access; dly = cycles of selection before the slave raises
    // ready (0 = ready on first selected cycle, negative = never).
    task automatic do_access(input string name, input logic [28:0] a, input logic [3:0] w,
                             input logic [31:0] d, input int dly);
        int          slot, exp_lat, exp_sel, cyc, sel_n, bad;
        logic        exp_err, got_err, done;
        logic [31:0] exp_rd, exp_mask, got_rd;

        slot     = int'(a[28:10]);
        exp_err  = 1'b0;
        exp_rd   = 32'h0;
        exp_sel  = 0;
        exp_lat  = 1;
        exp_mask = 32'h0;
        for (int b = 0; b < 4; b++) if (w[b]) exp_mask[8*b +: 8] = 8'hFF;

        if (slot < NSLOT) begin
            if (dly < 0 || dly >= TMO) begin
                exp_err = 1'b1;
                exp_lat = TMO + 1;
                exp_sel = TMO;
            end else begin
                exp_lat = dly + 2;
                exp_sel = dly + 1;
                if (w == 4'd0) exp_rd = slv_rdata[32*slot +: 32];
            end
        end else if (slot == NSLOT) begin
            if (w == 4'd0 && a[9:0] == 10'd0) exp_rd = {m_err_addr, 2'b00};
            if (w == 4'd0 && a[9:0] == 10'd1) exp_rd = {16'(m_count), 15'b0, m_irq};
        end else begin
            exp_err = 1'b1;
        end
        if (exp_err) exp_rd = ERR_RD;

        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_wren  = w;
        cpu_wdata = d;
        cyc = 0; sel_n = 0; bad = 0; done = 1'b0;
        got_rd = 32'h0; got_err = 1'b0;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cpu_ack === 1'b1) begin
                done    = 1'b1;
                got_rd  = cpu_rdata;
                got_err = cpu_err;
                cpu_req = 1'b0;
            end
            if (slv_sel !== '0) begin
                sel_n++;
                if (slot >= NSLOT || slv_sel !== NSLOT'(1 << slot) || slv_addr !== a[9:0] ||
                    slv_write_mask !== exp_mask || slv_wdata !== d) bad++;
            end
            slv_ready = (slv_sel !== '0 && dly >= 0 && sel_n == dly + 1 && slot < NSLOT) ?
                        NSLOT'(1 << slot) : '0;
        end
        cpu_req   = 1'b0;
        slv_ready = '0;

        check({name, "_ack_seen"}, 32'(done), 32'd1);
        if (done) begin
            check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
            check({name, "_err"}, 32'(got_err), 32'(exp_err));
            check({name, "_rdata"}, got_rd, exp_rd);
        end
        check({name, "_sel_cycles"}, 32'(sel_n), 32'(exp_sel));
        check({name, "_sel_fields"}, 32'(bad), 32'd0);

        if (exp_err) begin
            if (m_count == 0) m_err_addr = a;
            if (m_count < 65535) m_count++;
            m_irq = 1'b1;
        end else if (slot == NSLOT && a[9:0] == 10'd1 && w != 4'd0 && d[0]) begin
            m_count = 0;
            m_irq   = 1'b0;
        end

        @(posedge clk); #1;
        check({name, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
        check({name, "_irq"}, 32'(err_irq), 32'(m_irq));
    endtask

    initial begin
        int kind, dly, slot, ofs;
        logic [3:0]  w;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(cpu_ack), 32'd0);
        check("rst_err",   32'(cpu_err), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_sel",   32'(slv_sel), 32'h0);
        check("rst_saddr", 32'(slv_addr), 32'h0);
        check("rst_mask",  slv_write_mask, 32'h0);
        check("rst_wdata", slv_wdata, 32'h0);
        check("rst_irq",   32'(err_irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        slv_rdata[32*2 +: 32] = 32'hA5A5_0002;
        do_access("rd_slot2", 29'(30'h2014 >> 2), 4'b0000, 32'h0, 0);
        do_access("wr_slot0_dly3", mk_addr(0, 3), 4'b0011, 32'h1234_5678, 3);
        do_access("rd_slot1_dly4_tmo", mk_addr(1, 9), 4'b0000, 32'h0, 4);
        do_access("rd_slot3_tmo", mk_addr(3, 7), 4'b0000, 32'h0, -1);
        do_access("st_addr", mk_addr(NSLOT, 0), 4'b0000, 32'h0, 0);
        do_access("st_stat", mk_addr(NSLOT, 1), 4'b0000, 32'h0, 0);
        do_access("rd_unmapped9", mk_addr(9, 2), 4'b0000, 32'h0, 0);
        do_access("st_stat2", mk_addr(NSLOT, 1), 4'b0000, 32'h0, 0);
        do_access("st_addr2", mk_addr(NSLOT, 0), 4'b0000, 32'h0, 0);
        do_access("st_other", mk_addr(NSLOT, 5), 4'b0000, 32'h0, 0);
        do_access("st_clear", mk_addr(NSLOT, 1), 4'b1111, 32'h0000_0001, 0);
        do_access("st_stat_clr", mk_addr(NSLOT, 1), 4'b0000, 32'h0, 0);
        do_access("wr_slot5_tmo", mk_addr(5, 1), 4'b1000, 32'hCAFE_0000, -1);
        do_access("st_stat_after", mk_addr(NSLOT, 1), 4'b0000, 32'h0, 0);
        do_access("st_addr_after", mk_addr(NSLOT, 0), 4'b0000, 32'h0, 0);

        // Reset while a slot access is waiting
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = mk_addr(3, 4);
        cpu_wren = 4'b0000;
        @(posedge clk); #1;
        check("rstw_sel_before", 32'(slv_sel), 32'h08);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_sel",   32'(slv_sel), 32'h0);
        check("rstw_ack",   32'(cpu_ack), 32'd0);
        check("rstw_mask",  slv_write_mask, 32'h0);
        check("rstw_rdata", cpu_rdata, 32'h0);
        check("rstw_irq",   32'(err_irq), 32'd0);
        @(posedge clk); #1;
        check("rstw_ack_hold", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        cpu_req    = 1'b0;
        rst_n      = 1'b1;
        m_err_addr = '0;
        m_count    = 0;
        m_irq      = 1'b0;
        do_access("post_rst_rd", mk_addr(2, 5), 4'b0000, 32'h0, 1);

        for (int it = 0; it < 80; it++) begin
            for (int s = 0; s < NSLOT; s++) slv_rdata[32*s +: 32] = $urandom;
            kind = $urandom_range(0, 9);
            dly  = int'($urandom_range(0, 6)) - 1;
            w    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            d    = $urandom;
            if (kind <= 5) begin
                slot = $urandom_range(0, NSLOT - 1);
                ofs  = $urandom_range(0, 1023);
            end else if (kind <= 7) begin
                slot = NSLOT;
                ofs  = $urandom_range(0, 3);
            end else begin
                slot = $urandom_range(NSLOT + 1, 524287);
                ofs  = $urandom_range(0, 1023);
            end
            do_access($sformatf("rnd%0d", it), mk_addr(slot, ofs), w, d, dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
